spike_event_buffer: RTL and testbench

//  Downstream consumer of the SNN core's layer-2 output spikes. On every rising edge of the delay clock it

---
 rtl/snn_pkg.sv | 20 ++
 rtl/spike_fifo.sv | 89 ++++++++
 rtl/spike_event_buffer.sv | 93 +++++++++
 tb/tb_spike_event_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snn_pkg                                                          |
// | Shared widths and constants for the SNN spike readout path.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package snn_pkg;

    localparam int SPIKE_W  = 8;
    localparam int TS_W     = 8;
    localparam int ENTRY_W  = TS_W + SPIKE_W;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Saturating 8-bit increment used for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == DROP_MAX) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spike_fifo                                                       |
// | Single-clock FIFO with registered read, level count and clear.   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module spike_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_LEVEL_W = c_ADDR_W + 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_LEVEL_W-1:0] r_level;
    logic [WIDTH-1:0]     r_rd_data;
    logic                 r_rd_valid;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LEVEL_W'(DEPTH));
    assign w_pop   = i_rd_en & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_wr_en & (~w_full | w_pop);
    assign o_drop  = i_wr_en & ~w_push & ~i_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_W'(1);
                2'b01:   r_level <= r_level - c_LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_level    = r_level;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule
`default_nettype wire

// File: rtl/spike_event_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spike_event_buffer                                               |
// | Timestamps layer-2 spike vectors on delay-clock edges and queues |
// | them for the SPI readout path.                                   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module spike_event_buffer
    import snn_pkg::*;
#(
    parameter int N_OUT     = SPIKE_W,
    parameter int TS_WIDTH  = TS_W,
    parameter int DEPTH     = 16,
    parameter int SKIP_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      step_clk,
    input  logic [N_OUT-1:0]          spikes_in,
    input  logic                      rd_req,
    output logic [TS_WIDTH+N_OUT-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_count
);

    logic                r_step_q;
    logic [TS_WIDTH-1:0] r_ts;
    logic                r_overflow;
    logic [7:0]          r_drop_count;

    logic w_tick;
    logic w_zero;
    logic w_wr;
    logic w_drop;

    assign w_tick = step_clk & ~r_step_q & enable;
    assign w_zero = (spikes_in == '0);
    assign w_wr   = w_tick & ~((SKIP_ZERO != 0) & w_zero);

    // Edge register tracks step_clk even while capture is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step_clk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_ts         <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_tick) begin
                r_ts <= r_ts + TS_WIDTH'(1);
            end
            if (w_drop) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc8(r_drop_count);
            end
        end
    end

    spike_fifo #(
        .WIDTH (TS_WIDTH + N_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (clear),
        .i_wr_en    (w_wr),
        .i_wr_data  ({r_ts, spikes_in}),
        .i_rd_en    (rd_req),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_level    (level),
        .o_full     (full),
        .o_empty    (empty),
        .o_drop     (w_drop)
    );

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spike_event_buffer                                            |
// | Table-driven bench plus directed multi-cycle sequences.          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_spike_event_buffer;

    logic        clk = 1'b0;
    logic        reset, enable, clear, step_clk, rd_req;
    logic [7:0]  spikes_in;
    logic [15:0] rd_data;
    logic        rd_valid, empty, full, overflow;
    logic [4:0]  level;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    spike_event_buffer #(
        .N_OUT(8), .TS_WIDTH(8), .DEPTH(16), .SKIP_ZERO(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .step_clk(step_clk), .spikes_in(spikes_in), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, stp;
        logic [7:0]  sp;
        logic        rd, clr;
        logic        e_valid;
        logic [15:0] e_data;
        logic [4:0]  e_level;
        logic        e_empty, e_full, e_ovf;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic stp, input logic [7:0] sp,
                       input logic rd, input logic clr, input logic e_valid,
                       input logic [15:0] e_data, input logic [4:0] e_level,
                       input logic e_empty);
        vec_t v;
        v.en = en; v.stp = stp; v.sp = sp; v.rd = rd; v.clr = clr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_level = e_level;
        v.e_empty = e_empty; v.e_full = 1'b0; v.e_ovf = 1'b0; v.e_drop = 8'd0;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 ns after the edge.
    task automatic cyc(input logic en, input logic stp, input logic [7:0] sp,
                       input logic rd, input logic clr, input logic rst);
        enable = en; step_clk = stp; spikes_in = sp; rd_req = rd; clear = clr; reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic edge_in(input logic [7:0] sp);
        cyc(1'b1, 1'b1, sp, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //   en stp sp    rd clr | valid data     lvl empty
        add(1, 0, 8'h00, 0, 0,   0, 16'h0000, 0, 1);
        add(1, 1, 8'h81, 0, 0,   0, 16'h0000, 1, 0);
        add(1, 0, 8'h00, 0, 0,   0, 16'h0000, 1, 0);
        add(1, 1, 8'h00, 0, 0,   0, 16'h0000, 1, 0);
        add(1, 0, 8'h00, 0, 0,   0, 16'h0000, 1, 0);
        add(1, 1, 8'h3C, 0, 0,   0, 16'h0000, 2, 0);
        add(1, 0, 8'h00, 1, 0,   1, 16'h0081, 1, 0);
        add(1, 0, 8'h00, 0, 0,   0, 16'h0081, 1, 0);
        add(1, 0, 8'h00, 1, 0,   1, 16'h023C, 0, 1);
        add(1, 0, 8'h00, 1, 0,   0, 16'h023C, 0, 1);
        add(1, 1, 8'h55, 0, 1,   0, 16'h023C, 0, 1);
        add(1, 0, 8'h00, 0, 0,   0, 16'h023C, 0, 1);
        add(1, 1, 8'h42, 0, 0,   0, 16'h023C, 1, 0);
        add(1, 0, 8'h00, 1, 0,   1, 16'h0042, 0, 1);
        add(0, 1, 8'h11, 0, 0,   0, 16'h0042, 0, 1);
        add(0, 0, 8'h00, 0, 0,   0, 16'h0042, 0, 1);
        add(1, 1, 8'h22, 0, 0,   0, 16'h0042, 1, 0);
        add(1, 0, 8'h00, 1, 0,   1, 16'h0122, 0, 1);
        add(1, 1, 8'h77, 1, 0,   0, 16'h0122, 1, 0);
        add(1, 0, 8'h00, 1, 0,   1, 16'h0277, 0, 1);

        cyc(1, 0, 8'h00, 0, 0, 1);
        cyc(1, 0, 8'h00, 0, 0, 1);
        check("reset_data", rd_data, 16'h0000);
        check("reset_empty", empty, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].stp, vecs[i].sp, vecs[i].rd, vecs[i].clr, 1'b0);
            check($sformatf("v%0d_valid", i), rd_valid, vecs[i].e_valid);
            check($sformatf("v%0d_data", i), rd_data, vecs[i].e_data);
            check($sformatf("v%0d_level", i), level, vecs[i].e_level);
            check($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
            check($sformatf("v%0d_full", i), full, vecs[i].e_full);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
            check($sformatf("v%0d_drop", i), drop_count, vecs[i].e_drop);
        end

        // Fill to capacity, then two more edges overflow.
        cyc(1, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) edge_in(8'(i + 1));
        check("fill_full", full, 1'b1);
        check("fill_level", level, 5'd16);
        check("fill_ovf", overflow, 1'b0);
        edge_in(8'hAA);
        edge_in(8'hBB);
        check("ovf_full", full, 1'b1);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_drop", drop_count, 8'd2);
        check("ovf_level", level, 5'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'h00, 1, 0, 0);
            check($sformatf("drain%0d_valid", i), rd_valid, 1'b1);
            check($sformatf("drain%0d_data", i), rd_data, {8'(i), 8'(i + 1)});
        end
        cyc(1, 0, 8'h00, 0, 0, 0);
        check("drain_empty", empty, 1'b1);
        check("drain_valid", rd_valid, 1'b0);

        // Reset mid-fill with a coincident pop request.
        for (int i = 0; i < 5; i++) edge_in(8'h0F);
        check("prerst_level", level, 5'd5);
        check("prerst_ovf", overflow, 1'b1);
        cyc(1, 1, 8'h99, 1, 0, 1);
        check("rst_level", level, 5'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drop", drop_count, 8'd0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 16'h0000);
        cyc(1, 0, 8'h00, 0, 0, 0);
        check("postrst_level", level, 5'd0);

        // Full FIFO with a pop coincident with a tick.
        cyc(1, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) edge_in(8'(i + 1));
        cyc(1, 1, 8'hFF, 1, 0, 0);
        check("coinc_valid", rd_valid, 1'b1);
        check("coinc_data", rd_data, 16'h0001);
        check("coinc_level", level, 5'd16);
        check("coinc_full", full, 1'b1);
        check("coinc_drop", drop_count, 8'd0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'h00, 1, 0, 0);
            if (i < 15) check($sformatf("coinc_pop%0d", i), rd_data, {8'(i + 1), 8'(i + 2)});
            else        check("coinc_last", rd_data, 16'h10FF);
        end
        check("coinc_overflow", overflow, 1'b0);

        // Timestamp wrap: 257 edges, only the last nonzero.
        cyc(1, 0, 8'h00, 0, 1, 0);
        for (int k = 1; k <= 257; k++) edge_in((k == 257) ? 8'h01 : 8'h00);
        check("wrap_level", level, 5'd1);
        cyc(1, 0, 8'h00, 1, 0, 0);
        check("wrap_valid", rd_valid, 1'b1);
        check("wrap_data", rd_data, 16'h0001);
        check("wrap_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
